// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder and its array.
package mips_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int BE_W            = 4;
  localparam int DEF_DEPTH_LOG2  = 8;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word array with synchronous byte-enabled write and synchronous read.
// Contents are intentionally not reset; rdata holds its value until the next read.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // One access per enabled cycle: byte-lane write, or a registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for a MIPS CPU: request/response handshake with a fixed
// number of wait states in front of a word array.
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to reject misaligned
// requests with rsp_err=1 (store suppressed, rdata forced to 0).
//
// state   | meaning
// IDLE    | ready for a request (req_ready=1 once out of reset)
// WAIT    | counting wait states for the accepted request
// RESP    | response presented until rsp_ready
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam bit DIRECT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = DIRECT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    rst_done_q;
  logic                    lat_we, lat_mis;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [WORD_W-1:0]       lat_wdata;
  logic [BE_W-1:0]         lat_be;
  logic                    accept, req_mis, access;
  logic                    cur_we, cur_mis;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [WORD_W-1:0]       cur_wdata;
  logic [BE_W-1:0]         cur_be;
  logic [WORD_W-1:0]       arr_rdata;
  logic                    unused_addr;

  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  // With no wait states the array access happens on the accepting edge, so
  // the live request feeds the array instead of the not-yet-latched copy.
  assign access    = DIRECT ? (state_q == ST_IDLE && accept)
                            : (state_q == ST_WAIT && wait_cnt_q == '0);
  assign cur_we    = DIRECT ? req_we    : lat_we;
  assign cur_mis   = DIRECT ? req_mis   : lat_mis;
  assign cur_idx   = DIRECT ? req_addr[DEPTH_LOG2+1:2] : lat_idx;
  assign cur_wdata = DIRECT ? req_wdata : lat_wdata;
  assign cur_be    = DIRECT ? req_be    : lat_be;

  mips_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (access && !cur_mis),
    .we    (cur_we),
    .be    (cur_be),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // State register; rst_done_q keeps req_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = DIRECT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait-state down-counter, loaded on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (accept) begin
      wait_cnt_q <= CNT_LOAD;
    end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
      wait_cnt_q <= wait_cnt_q - 1'b1;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_mis   <= req_mis;
      lat_idx   <= req_addr[DEPTH_LOG2+1:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Outputs decoded from state and the captured request.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && rst_done_q;
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = (rsp_valid && !lat_we && !lat_mis) ? arr_rdata : '0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    rsp_err   = rsp_valid && lat_mis;
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder (default parameters).
module tb_mips_mem_responder;

  localparam int WAITS   = 2;
  localparam int EXP_LAT = WAITS + 1;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [256];

  mips_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [3:0] be);
    int idx;
    idx = (addr >> 2) % 256;
    for (int b = 0; b < 4; b++)
      if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
  endfunction

  function automatic bit is_mis(input logic [31:0] addr);
    return ALIGN_CHK && (addr % 4 != 0);
  endfunction

  // Issue one request and return with rsp_valid observed (rsp_ready still 0).
  // lat counts cycles from acceptance to first rsp_valid; -1 on timeout.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    lat = -1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_be = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_fill();
    int lat;
    logic [31:0] wd;
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      model[i] = wd;
      send(1'b1, i * 4, wd, 4'hF, lat);
      checks++;
      if (lat !== EXP_LAT || rsp_rdata !== 32'd0) begin
        failures++;
        $display("FAIL fill_%0d: got lat=%0d rdata=%h, want lat=%0d rdata=0", i, lat, rsp_rdata, EXP_LAT);
      end
      consume();
    end
  endtask

  task automatic test_store_load();
    int lat;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (lat !== EXP_LAT || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL store_rsp: got lat=%0d rdata=%h err=%b, want %0d 0 0", lat, rsp_rdata, rsp_err, EXP_LAT);
    end
    consume();
    send(1'b0, 32'h10, 32'h0, 4'h0, lat);
    checks++;
    if (lat !== EXP_LAT || rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_rsp: got lat=%0d rdata=%h, want %0d DEADBEEF", lat, rsp_rdata, EXP_LAT);
    end
    consume();
  endtask

  task automatic test_partial();
    int lat;
    send(1'b1, 32'h10, 32'h000000AA, 4'h1, lat);
    model_write(32'h10, 32'h000000AA, 4'h1);
    consume();
    send(1'b0, 32'h10, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== 32'hDEADBEAA || model[4] !== 32'hDEADBEAA) begin
      failures++;
      $display("FAIL partial_store: got %h, want DEADBEAA", rsp_rdata);
    end
    consume();
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat);
    checks++;
    if (lat !== EXP_LAT) begin
      failures++;
      $display("FAIL be_zero_rsp: got lat=%0d, want %0d", lat, EXP_LAT);
    end
    consume();
    send(1'b0, 32'h10, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== model[4]) begin
      failures++;
      $display("FAIL be_zero_unchanged: got %h, want %h", rsp_rdata, model[4]);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] wd;
    wd = $urandom;
    send(1'b1, 32'h30, wd, 4'h2, lat);
    model_write(32'h30, wd, 4'h2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_wdata = $urandom; req_be = 4'hF; req_we = 1'b1; req_addr = 32'h30;
    end
    consume();
    send(1'b0, 32'h30, 32'h0, 4'h0, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== model[12]) begin
        failures++;
        $display("FAIL backpressure_%0d: got valid=%b ready=%b rdata=%h, want 1 0 %h",
                 c, rsp_valid, req_ready, rsp_rdata, model[12]);
      end
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp;
    send(1'b0, 32'h10, 32'h0, 4'h0, lat);
    exp = model[4];
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_be = 4'h0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL consume_cycle_ready: got %b, want 0", req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || exp !== model[4]) begin
      failures++;
      $display("FAIL after_consume: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== EXP_LAT || rsp_rdata !== model[12]) begin
      failures++;
      $display("FAIL back_to_back: got lat=%0d rdata=%h, want %0d %h", lat, rsp_rdata, EXP_LAT, model[12]);
    end
    consume();
  endtask

  task automatic test_wrap();
    int lat;
    send(1'b1, 32'h400, 32'h12345678, 4'hF, lat);
    model_write(32'h400, 32'h12345678, 4'hF);
    consume();
    send(1'b0, 32'h000, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL wrap: got %h, want 12345678", rsp_rdata);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] old;
    old = model[8];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = ~old; req_be = 4'hF;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ready=%b valid=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_hold: got ready=%b valid=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    send(1'b0, 32'h20, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== old) begin
      failures++;
      $display("FAIL reset_mid_nowrite: got %h, want %h", rsp_rdata, old);
    end
    consume();
  endtask

  task automatic test_misalign();
    int lat;
    logic [31:0] wd;
    wd = $urandom;
    send(1'b1, 32'h13, wd, 4'hF, lat);
    checks++;
    if (lat !== EXP_LAT || rsp_err !== ALIGN_CHK || rsp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL misalign_store: got lat=%0d err=%b rdata=%h, want %0d %b 0",
               lat, rsp_err, rsp_rdata, EXP_LAT, ALIGN_CHK);
    end
    if (!is_mis(32'h13)) model_write(32'h13, wd, 4'hF);
    consume();
    send(1'b0, 32'h10, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== model[4] || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_word: got %h err=%b, want %h 0", rsp_rdata, rsp_err, model[4]);
    end
    consume();
    send(1'b0, 32'h11, 32'h0, 4'h0, lat);
    checks++;
    if (rsp_rdata !== (ALIGN_CHK ? 32'd0 : model[4]) || rsp_err !== ALIGN_CHK) begin
      failures++;
      $display("FAIL misalign_load: got %h err=%b", rsp_rdata, rsp_err);
    end
    consume();
  endtask

  task automatic test_random();
    int lat, hold, idx;
    logic we, mis;
    logic [31:0] addr, wd, exp_rd;
    logic [3:0] be;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      wd = $urandom;
      be = 4'($urandom);
      mis = is_mis(addr);
      idx = (addr >> 2) % 256;
      exp_rd = (we || mis) ? 32'd0 : model[idx];
      if (we && !mis) model_write(addr, wd, be);
      send(we, addr, wd, be, lat);
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        checks++;
        if (lat !== EXP_LAT || rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== mis) begin
          failures++;
          $display("FAIL random_%0d: we=%b addr=%h got lat=%0d valid=%b rdata=%h err=%b, want %0d 1 %h %b",
                   n, we, addr, lat, rsp_valid, rsp_rdata, rsp_err, EXP_LAT, exp_rd, mis);
        end
        if (c < hold) @(negedge clk);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 words of 32 bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request acceptance and response, legal range 0..15.
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have req_valid, input, 1: the CPU presents a request.
REQ-006 SHALL have req_ready, output, 1: the responder accepts the request this cycle.
REQ-007 SHALL have req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have req_addr, input, 32: byte address.
REQ-009 SHALL have req_wdata, input, 32: store data.
REQ-010 SHALL have req_be, input, 4: store byte enables; bit i writes byte i (bits 8i+7:8i).
REQ-011 SHALL have rsp_valid, output, 1: a response is present.
REQ-012 SHALL have rsp_ready, input, 1: the CPU consumes the response.
REQ-013 SHALL have rsp_rdata, output, 32: load data; 0 for stores.
REQ-014 SHALL have rsp_err, output, 1: the request was rejected (see REQ-027).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; acceptance occurs when req_valid && req_ready.
REQ-017 SHALL, on acceptance, latch we/addr/wdata/be and go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-018 SHALL count WAIT_CYCLES cycles in WAIT, then move to RESP; first rsp_valid occurs WAIT_CYCLES+1 cycles after acceptance.
REQ-019 SHALL perform the store (byte-enabled) and capture the load data on the WAIT->RESP transition, exactly once per request.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on the next edge.
REQ-021 SHALL NOT accept a new request in the cycle the response is consumed; the earliest next acceptance is the following cycle (IDLE).
REQ-022 SHALL index the memory with req_addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-023 SHALL, for a store with req_be=0, leave memory unchanged and still return a response.
REQ-024 SHALL drive rsp_rdata=0 whenever rsp_valid=0 or the request was a store.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, wait counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready rises in the first cycle after release.
REQ-026 SHALL abandon any in-flight request on reset with no memory write; memory contents are not reset.

Configuration
REQ-027 SHALL, with MEM_RESP_ALIGN_CHECK_EN defined, treat req_addr[1:0]!=0 as misaligned: suppress the store, return rsp_rdata=0 and rsp_err=1, with unchanged latency.
REQ-028 SHALL, without MEM_RESP_ALIGN_CHECK_EN, tie rsp_err to 0 and ignore req_addr[1:0].

Structure
REQ-029 SHALL place the FSM state enum, WORD_W=32, BE_W=4 and the default DEPTH_LOG2/WAIT_CYCLES constants in the shared package mips_mem_pkg.
REQ-030 SHALL instantiate one sub-module, mips_mem_array: a single-port 2^DEPTH_LOG2 x 32 array with synchronous byte-enabled write and read.

Verification
REQ-031 SHALL cover store then load: store 0xDEADBEEF to 0x10 (be=0xF), then load 0x10 -> rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after each acceptance (WAIT_CYCLES=2).
REQ-032 SHALL cover partial store: store 0x000000AA to 0x10 with be=0x1, then load -> 0xDEADBEAA.
REQ-033 SHALL cover backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout, one write only.
REQ-034 SHALL cover wrap-around: store 0x12345678 to 0x400 (DEPTH_LOG2=8) -> a load from 0x000 returns 0x12345678.
REQ-035 SHALL cover reset mid-operation: assert rst_n=0 in WAIT of a store to 0x20 -> no write, outputs zero, the old 0x20 content is read back after release.
REQ-036 SHALL cover misalignment: store to 0x13 -> with MEM_RESP_ALIGN_CHECK_EN, rsp_err=1 and memory unchanged; without it, rsp_err=0 and word 0x10 is written.
